fft_frame_sink: RTL and testbench
=================================

Name: fft_frame_sink

Overview:
- Hardware sink for the fft_multimode output stream (valid_out/sop_out/y_re/y_im).
- Captures one complete output frame of 64/128/256/512 points into an internal buffer.
- Replays the captured frame over a valid/ready read stream.
- Used on silicon and in system benches in place of the file-dump sink.

Parameters:
- DW, 16, sample width of each of re/im.
- MAX_N, 512, buffer depth in points.
- AW, 9, address width, equal to log2(MAX_N).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- np  in  2  frame length select: 00=64, 01=128, 10=256, 11=512
- valid_in  in  1  input sample qualifier (from FFT valid_out)
- sop_in  in  1  first sample of frame (from FFT sop_out); qualified by valid_in
- y_re_in  in  DW  real part
- y_im_in  in  DW  imaginary part
- busy  out  1  high in CAPTURE, READY and READOUT
- frame_done  out  1  one-cycle pulse when the last point of a frame is written
- sop_err  out  1  one-cycle pulse on a restart caused by sop mid-frame
- ovf  out  1  sticky; an input sample was dropped while the buffer was full
- rd_ready  in  1  downstream accept
- rd_valid  out  1  read sample valid
- rd_sop  out  1  first read sample (index 0)
- rd_eop  out  1  last read sample (index N-1)
- rd_idx  out  AW  index of the current read sample
- rd_re  out  DW  read real part
- rd_im  out  DW  read imaginary part

Behaviour:
- Reset: one clock, clk; rst is asynchronous and active-high.
  - While rst is high, all outputs are 0, state is IDLE, and all counters are 0.
  - Buffer contents are undefined after reset.
- N = 64 << np. np is latched only when a frame starts; np changes mid-frame are ignored.
- States: IDLE, CAPTURE, READY, READOUT.
- IDLE:
  - valid_in&sop_in writes the sample to index 0, latches N, clears ovf, and goes to CAPTURE with wr_cnt=1.
  - valid_in without sop_in is ignored; ovf is not set.
- CAPTURE:
  - Each valid_in writes to wr_cnt and increments it. valid_in low cycles (gaps) are allowed; nothing is written.
  - valid_in&sop_in writes to index 0, sets wr_cnt=1, re-latches N, and pulses sop_err the next cycle.
  - Writing index N-1 pulses frame_done the next cycle and moves to READY.
- READY:
  - The read pipeline is primed; rd_valid rises exactly 2 cycles after entering READY, with rd_idx=0 and rd_sop=1.
  - State then moves to READOUT.
- READOUT:
  - A transfer occurs when rd_valid&rd_ready.
  - rd_re/rd_im/rd_idx/rd_sop/rd_eop stay stable while rd_valid&!rd_ready.
  - With rd_ready held high, one sample transfers per cycle with no bubbles.
  - The transfer with rd_eop=1 drops rd_valid the next cycle and returns to IDLE.
- Valid input arriving in READY or READOUT is dropped and sets ovf. This includes sop_in; no new frame starts.
- ovf clears only on reset or on the next accepted frame start.
- In IDLE, a sop_in in the same cycle as the final READOUT transfer is not accepted. The transition to IDLE completes first.
- Reset asserted mid-capture or mid-readout aborts immediately. rd_valid drops asynchronously.
- No arithmetic on the data; samples are stored and returned bit-exact in arrival order.

Decomposition:
- Shared package fft_pkg holds:
  - np encoding constants (NP_64..NP_512);
  - function np_to_len(np) returning an AW+1-bit value;
  - the state enumeration for this block;
  - DW and MAX_N defaults.
- One sub-module, fft_sink_ram: simple dual-port RAM, MAX_N x 2*DW.
  - Write port: we, waddr, wdata.
  - Read port: re, raddr, rdata, with 1-cycle registered read latency.
- Top level holds the FSM, the counters, and the read skid/hold register that gives bubble-free flow under backpressure.

Test Plan:
- 64-pt frame, np=00, sop on the first sample, data re=k, im=0x8000+k with no gaps, rd_ready=1.
  - frame_done pulses once after sample 63.
  - rd_valid rises 2 cycles after READY.
  - Readout gives 64 consecutive beats re=0..63, rd_sop at idx 0, rd_eop at idx 63, then IDLE and busy=0.
- 512-pt frame, np=11, valid_in toggling 1-0-1.
  - All 512 samples are captured.
  - Readout matches input in order; frame_done fires once.
- sop_in reasserted at sample 20 of a 128-pt frame.
  - sop_err pulses once.
  - Readout returns the 128 samples that follow the second sop; idx 0 equals the second sop sample.
- rd_ready pattern 1,0,0,1 repeating during a 64-pt readout.
  - Outputs hold stable while stalled.
  - No duplicated or skipped indices; exactly 64 transfers.
- Input frame sent during READOUT.
  - ovf goes to 1 and the readout data is unaffected.
  - The next accepted sop in IDLE clears ovf.
- rst pulsed at capture index 30, then a fresh 64-pt frame.
  - All outputs are 0 during reset.
  - The new frame reads out correctly with no stale frame_done.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and constants for the fft_multimode output-side blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fft_pkg;

    localparam int DW_DEF    = 16;
    localparam int MAX_N_DEF = 512;
    localparam int AW_DEF    = 9;

    // Frame length select encoding shared with the FFT core
    localparam logic [1:0] NP_64  = 2'b00;
    localparam logic [1:0] NP_128 = 2'b01;
    localparam logic [1:0] NP_256 = 2'b10;
    localparam logic [1:0] NP_512 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_READY,
        ST_READOUT
    } sink_state_t;

    // Number of points in a frame for a given np code (64 << np)
    function automatic logic [AW_DEF:0] np_to_len(input logic [1:0] np);
        logic [AW_DEF:0] len;
        case (np)
            NP_64:   len = (AW_DEF+1)'(64);
            NP_128:  len = (AW_DEF+1)'(128);
            NP_256:  len = (AW_DEF+1)'(256);
            default: len = (AW_DEF+1)'(512);
        endcase
        return len;
    endfunction

endpackage

// File: rtl/fft_sink_ram.sv
// Simple dual-port frame buffer, one word = {re, im}.
// Latency: write lands on the clock edge; read data registered 1 cycle after re.
// Backpressure: none; rdata holds its last value while re is low.
module fft_sink_ram
    import fft_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int MAX_N = MAX_N_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [2*DW-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [2*DW-1:0] rdata
);

    logic [2*DW-1:0] mem [MAX_N];

    // Storage write and registered read; no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_frame_sink.sv
// Captures one FFT output frame (64..512 points) and replays it on a valid/ready stream.
// Latency: rd_valid rises 2 cycles after the frame completes; then 1 sample/cycle.
// Backpressure: rd_ready low holds the output beat; input arriving while full is dropped and flagged in ovf.
module fft_frame_sink
    import fft_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int MAX_N = MAX_N_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    np,
    input  logic          valid_in,
    input  logic          sop_in,
    input  logic [DW-1:0] y_re_in,
    input  logic [DW-1:0] y_im_in,
    output logic          busy,
    output logic          frame_done,
    output logic          sop_err,
    output logic          ovf,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic          rd_sop,
    output logic          rd_eop,
    output logic [AW-1:0] rd_idx,
    output logic [DW-1:0] rd_re,
    output logic [DW-1:0] rd_im
);

    sink_state_t     state, state_nxt;
    logic [AW:0]     n_len;
    logic [AW:0]     n_last;
    logic [AW-1:0]   wr_cnt;
    logic [AW:0]     rd_cnt;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            frame_last;
    logic            rd_issue;
    logic            s1_vld;
    logic [AW-1:0]   s1_idx;
    logic            adv;
    logic [2*DW-1:0] ram_rdata;

    assign n_last = n_len - (AW+1)'(1);
    assign busy   = (state != ST_IDLE);
    // Output register may take a new beat when empty or when its beat is accepted
    assign adv    = !rd_valid || rd_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, buffer write strobe and read issue
    always_comb begin
        state_nxt  = state;
        wr_en      = 1'b0;
        wr_addr    = wr_cnt;
        frame_last = 1'b0;
        rd_issue   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid_in && sop_in) begin
                    wr_en     = 1'b1;
                    wr_addr   = '0;
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (valid_in) begin
                    wr_en = 1'b1;
                    if (sop_in) begin
                        // Restart: this sample becomes point 0 of a new frame
                        wr_addr = '0;
                    end else if ({1'b0, wr_cnt} == n_last) begin
                        frame_last = 1'b1;
                        state_nxt  = ST_READY;
                    end
                end
            end
            ST_READY: begin
                // Prime the pipeline with point 0; stage 1 is empty here
                rd_issue  = 1'b1;
                state_nxt = ST_READOUT;
            end
            ST_READOUT: begin
                rd_issue = (rd_cnt != n_len) && (!s1_vld || adv);
                if (rd_valid && rd_ready && rd_eop) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame length, write/read counters, status pulses and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_len      <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            frame_done <= 1'b0;
            sop_err    <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            frame_done <= frame_last;
            sop_err    <= (state == ST_CAPTURE) && valid_in && sop_in;
            if (valid_in && sop_in && (state == ST_IDLE || state == ST_CAPTURE)) begin
                n_len  <= (AW+1)'(np_to_len(np));
                wr_cnt <= AW'(1);
                if (state == ST_IDLE) begin
                    ovf <= 1'b0;
                end
            end else if (frame_last) begin
                wr_cnt <= '0;
            end else if (valid_in && state == ST_CAPTURE) begin
                wr_cnt <= wr_cnt + AW'(1);
            end
            if (valid_in && (state == ST_READY || state == ST_READOUT)) begin
                ovf <= 1'b1;
            end
            if (frame_last) begin
                rd_cnt <= '0;
            end else if (rd_issue) begin
                rd_cnt <= rd_cnt + (AW+1)'(1);
            end
        end
    end

    // Read pipeline: RAM output stage (s1) feeding the held output beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s1_idx   <= '0;
            rd_valid <= 1'b0;
            rd_sop   <= 1'b0;
            rd_eop   <= 1'b0;
            rd_idx   <= '0;
            rd_re    <= '0;
            rd_im    <= '0;
        end else begin
            if (rd_issue) begin
                s1_vld <= 1'b1;
                s1_idx <= rd_cnt[AW-1:0];
            end else if (adv) begin
                s1_vld <= 1'b0;
            end
            if (adv) begin
                rd_valid <= s1_vld;
                if (s1_vld) begin
                    rd_idx <= s1_idx;
                    rd_sop <= (s1_idx == '0);
                    rd_eop <= ({1'b0, s1_idx} == n_last);
                    rd_re  <= ram_rdata[2*DW-1:DW];
                    rd_im  <= ram_rdata[DW-1:0];
                end
            end
        end
    end

    fft_sink_ram #(
        .DW    (DW),
        .MAX_N (MAX_N),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata ({y_re_in, y_im_in}),
        .re    (rd_issue),
        .raddr (rd_cnt[AW-1:0]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_fft_frame_sink.sv
// Scoreboard bench for fft_frame_sink: directed frames, expected beats queued at stimulus time.
// Latency: checks rd_valid rising 2 cycles after frame_done.
// Backpressure: exercises a 1,0,0,1 rd_ready pattern and hold stability.
module tb_fft_frame_sink;
    import fft_pkg::*;

    localparam int DW = 16;
    localparam int AW = 9;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          sop;
        logic          eop;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    np;
    logic          valid_in, sop_in;
    logic [DW-1:0] y_re_in, y_im_in;
    logic          busy, frame_done, sop_err, ovf;
    logic          rd_ready, rd_valid, rd_sop, rd_eop;
    logic [AW-1:0] rd_idx;
    logic [DW-1:0] rd_re, rd_im;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    fd_cnt = 0;
    int    se_cnt = 0;
    int    xfer_cnt = 0;
    int    rdy_mode = 0;

    always #5 clk = ~clk;

    fft_frame_sink dut (
        .clk        (clk),
        .rst        (rst),
        .np         (np),
        .valid_in   (valid_in),
        .sop_in     (sop_in),
        .y_re_in    (y_re_in),
        .y_im_in    (y_im_in),
        .busy       (busy),
        .frame_done (frame_done),
        .sop_err    (sop_err),
        .ovf        (ovf),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_sop     (rd_sop),
        .rd_eop     (rd_eop),
        .rd_idx     (rd_idx),
        .rd_re      (rd_re),
        .rd_im      (rd_im)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Sends total = restart_at + n_pts samples; sop on sample 0 and on sample restart_at (if nonzero).
    // np is flipped after each sop sample to show mid-frame changes are ignored.
    task automatic send_frame(input logic [1:0] npv, input int n_pts, input int base,
                              input int gap, input int restart_at, input bit push);
        int total = restart_at + n_pts;
        int nfull = 64 << npv;
        for (int i = 0; i < total; i++) begin
            @(posedge clk); #1;
            valid_in = 1'b1;
            sop_in   = (i == 0) || (restart_at != 0 && i == restart_at);
            np       = sop_in ? npv : ~npv;
            y_re_in  = 16'(base + i);
            y_im_in  = 16'(32'h8000 + i);
            if (push && i >= restart_at) begin
                beat_t b;
                b.idx = AW'(i - restart_at);
                b.re  = 16'(base + i);
                b.im  = 16'(32'h8000 + i);
                b.sop = (i == restart_at);
                b.eop = ((i - restart_at) == nfull - 1);
                exp_q.push_back(b);
            end
            if (gap != 0) begin
                @(posedge clk); #1;
                valid_in = 1'b0;
                sop_in   = 1'b0;
            end
        end
        if (gap == 0) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
            sop_in   = 1'b0;
        end
    endtask

    task automatic wait_fd(input int budget);
        int c = 0;
        @(negedge clk);
        while (!frame_done && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("frame_done_seen", 64'(frame_done), 64'd1);
    endtask

    task automatic check_latency();
        check("rdv_lat0", 64'(rd_valid), 64'd0);
        @(negedge clk);
        check("rdv_lat1", 64'(rd_valid), 64'd0);
        @(negedge clk);
        check("rdv_lat2", {rd_valid, rd_sop, rd_idx}, {1'b1, 1'b1, 9'd0});
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        @(negedge clk);
        while ((busy || rd_valid || exp_q.size() != 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("idle", {busy, rd_valid, exp_q.size() == 0}, 3'b001);
    endtask

    initial begin
        int fdb, xb, seb;
        rst = 1'b1; np = 2'b00; valid_in = 1'b0; sop_in = 1'b0;
        y_re_in = '0; y_im_in = '0; rd_ready = 1'b1;

        fork
            begin : monitor
                logic [63:0] held = '0;
                bit          stalled = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        stalled = 1'b0;
                    end else begin
                        if (frame_done) fd_cnt++;
                        if (sop_err) se_cnt++;
                        if (stalled)
                            check("hold", 64'({rd_valid, rd_sop, rd_eop, rd_idx, rd_re, rd_im}), held);
                        if (rd_valid && rd_ready) begin
                            xfer_cnt++;
                            if (exp_q.size() == 0) begin
                                n_cmp++;
                                n_bad++;
                                $display("FAIL beat: unexpected idx %0d re %0h with empty scoreboard", rd_idx, rd_re);
                            end else begin
                                beat_t e;
                                e = exp_q.pop_front();
                                check("beat", 64'({rd_idx, rd_re, rd_im, rd_sop, rd_eop}), 64'(e));
                            end
                        end
                        stalled = rd_valid && !rd_ready;
                        held    = 64'({rd_valid, rd_sop, rd_eop, rd_idx, rd_re, rd_im});
                    end
                end
            end
            begin : ready_drv
                int ph = 0;
                forever begin
                    @(posedge clk); #1;
                    ph++;
                    if (rdy_mode == 0) rd_ready = 1'b1;
                    else               rd_ready = (ph % 4 == 0) || (ph % 4 == 3);
                end
            end
            begin : watchdog
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        @(negedge clk); @(negedge clk);
        check("reset_outs", {busy, frame_done, sop_err, ovf, rd_valid, rd_sop, rd_eop, rd_idx, rd_re, rd_im}, '0);
        @(posedge clk); #1 rst = 1'b0;

        // valid without sop in IDLE is ignored
        @(posedge clk); #1 valid_in = 1'b1; sop_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 valid_in = 1'b0;
        @(negedge clk);
        check("idle_stray", {busy, ovf}, 2'b00);

        // 64-pt, re=k, im=0x8000+k, no gaps
        fdb = fd_cnt; xb = xfer_cnt;
        send_frame(NP_64, 64, 0, 0, 0, 1'b1);
        wait_fd(50);
        check_latency();
        wait_idle(300);
        check("t1_fd", 64'(fd_cnt - fdb), 64'd1);
        check("t1_xfer", 64'(xfer_cnt - xb), 64'd64);
        check("t1_ovf", 64'(ovf), 64'd0);

        // 512-pt with valid toggling
        fdb = fd_cnt; xb = xfer_cnt;
        send_frame(NP_512, 512, 16'h1000, 1, 0, 1'b1);
        wait_fd(50);
        check_latency();
        wait_idle(1200);
        check("t2_fd", 64'(fd_cnt - fdb), 64'd1);
        check("t2_xfer", 64'(xfer_cnt - xb), 64'd512);

        // 128-pt with sop restart at sample 20
        fdb = fd_cnt; xb = xfer_cnt; seb = se_cnt;
        send_frame(NP_128, 128, 16'h3000, 0, 20, 1'b1);
        wait_fd(50);
        wait_idle(400);
        check("t3_sop_err", 64'(se_cnt - seb), 64'd1);
        check("t3_fd", 64'(fd_cnt - fdb), 64'd1);
        check("t3_xfer", 64'(xfer_cnt - xb), 64'd128);

        // rd_ready 1,0,0,1 during a 64-pt readout
        xb = xfer_cnt;
        rdy_mode = 1;
        send_frame(NP_64, 64, 16'h4000, 0, 0, 1'b1);
        wait_fd(50);
        check_latency();
        wait_idle(600);
        rdy_mode = 0;
        check("t4_xfer", 64'(xfer_cnt - xb), 64'd64);

        // Input during READOUT sets ovf; next accepted sop clears it
        fdb = fd_cnt;
        send_frame(NP_64, 64, 16'h5000, 0, 0, 1'b1);
        wait_fd(50);
        send_frame(NP_64, 10, 16'h6000, 0, 0, 1'b0);
        @(negedge clk);
        check("t5_ovf_set", {busy, ovf}, 2'b11);
        wait_idle(300);
        check("t5_ovf_sticky", 64'(ovf), 64'd1);
        send_frame(NP_64, 64, 16'h7000, 0, 0, 1'b1);
        check("t5_ovf_clr", 64'(ovf), 64'd0);
        wait_fd(50);
        wait_idle(300);
        check("t5_fd", 64'(fd_cnt - fdb), 64'd2);

        // Reset at capture index 30, then a fresh frame
        send_frame(NP_64, 30, 16'h0100, 0, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_reset_outs", {busy, frame_done, sop_err, ovf, rd_valid, rd_sop, rd_eop, rd_idx, rd_re, rd_im}, '0);
        @(posedge clk); #1 rst = 1'b0;
        fdb = fd_cnt;
        send_frame(NP_64, 64, 16'h0200, 0, 0, 1'b1);
        wait_fd(50);
        wait_idle(300);
        check("t6_fd", 64'(fd_cnt - fdb), 64'd1);

        // Reset mid-readout drops rd_valid without waiting for a clock
        send_frame(NP_64, 64, 16'h0300, 0, 0, 1'b1);
        wait_fd(50);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1 check("t7_async_rst", {rd_valid, busy}, 2'b00);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t7_after_rst", {busy, rd_valid, ovf}, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
